// File: rtl/fft_r2_ctrl_if.sv
// Control bus between the radix-2 FFT sequencer and its RAM/ROM/butterfly datapath.
interface fft_r2_ctrl_if #(
    parameter int LOG2_N = 3
);
    localparam int TW_W = (LOG2_N > 1) ? LOG2_N - 1 : 1;

    logic              start;
    logic              busy;
    logic              done;
    logic [LOG2_N-1:0] stage;
    logic              rd_en;
    logic [LOG2_N-1:0] rd_addr_a;
    logic [LOG2_N-1:0] rd_addr_b;
    logic [TW_W-1:0]   tw_idx;
    logic              wr_en;
    logic [LOG2_N-1:0] wr_addr_a;
    logic [LOG2_N-1:0] wr_addr_b;

    modport master (
        input  start,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_r2_ctrl.sv
// In-place radix-2 DIT FFT sequencer: issues N/2 butterfly ops per stage through one
// shared butterfly and replays each read address as a write-back PIPE_LAT cycles later.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one butterfly op issued per cycle, j = 0..N/2-1
// DRAIN   | PIPE_LAT idle cycles so the stage's last write lands before the next stage reads
// DONE    | one-cycle done pulse, busy low
module fft_r2_ctrl #(
    parameter int LOG2_N   = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fft_r2_ctrl_if.master io_bus
);
    localparam int N    = 1 << LOG2_N;
    localparam int TW_W = (LOG2_N > 1) ? LOG2_N - 1 : 1;
    localparam int JW   = TW_W;
    localparam int DW   = $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [LOG2_N-1:0] r_stage, w_stage_nxt;
    logic [JW-1:0]     r_j, w_j_nxt;
    logic [DW-1:0]     r_drain, w_drain_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              w_issue;
    logic              r_rd_en;
    logic [LOG2_N-1:0] r_rd_a, r_rd_b, w_rd_a_nxt, w_rd_b_nxt;
    logic [TW_W-1:0]   r_tw, w_tw_nxt;
    logic              r_pipe_en [PIPE_LAT];
    logic [LOG2_N-1:0] r_pipe_a  [PIPE_LAT];
    logic [LOG2_N-1:0] r_pipe_b  [PIPE_LAT];

    function automatic logic [LOG2_N-1:0] f_low_mask(input logic [LOG2_N-1:0] s);
        return (LOG2_N'(1) << s) - LOG2_N'(1);
    endfunction

    // Upper address: op index with a zero bit inserted at position 'stage'.
    function automatic logic [LOG2_N-1:0] f_addr_a(input logic [LOG2_N-1:0] s,
                                                   input logic [LOG2_N-1:0] j);
        return ((j >> s) << (s + LOG2_N'(1))) | (j & f_low_mask(s));
    endfunction

    function automatic logic [TW_W-1:0] f_tw(input logic [LOG2_N-1:0] s,
                                             input logic [LOG2_N-1:0] j);
        logic [LOG2_N-1:0] sh;
        sh = LOG2_N'(LOG2_N - 1) - s;
        return TW_W'((j & f_low_mask(s)) << sh);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_j_nxt     = r_j;
        w_drain_nxt = r_drain;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_issue     = 1'b0;
        w_rd_a_nxt  = '0;
        w_rd_b_nxt  = '0;
        w_tw_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_state_nxt = S_RUN;
                    w_stage_nxt = '0;
                    w_j_nxt     = '0;
                    w_busy_nxt  = 1'b1;
                    w_issue     = 1'b1;
                end
            end
            S_RUN: begin
                if (r_j == JW'(N / 2 - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DW'(PIPE_LAT - 1);
                end else begin
                    w_j_nxt = r_j + JW'(1);
                    w_issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) begin
                    if (r_stage == LOG2_N'(LOG2_N - 1)) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_stage_nxt = r_stage + LOG2_N'(1);
                        w_j_nxt     = '0;
                        w_issue     = 1'b1;
                    end
                end else begin
                    w_drain_nxt = r_drain - DW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_issue) begin
            w_rd_a_nxt = f_addr_a(w_stage_nxt, LOG2_N'(w_j_nxt));
            w_rd_b_nxt = w_rd_a_nxt + (LOG2_N'(1) << w_stage_nxt);
            w_tw_nxt   = f_tw(w_stage_nxt, LOG2_N'(w_j_nxt));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_j     <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_pipe_en[i] <= 1'b0;
                r_pipe_a[i]  <= '0;
                r_pipe_b[i]  <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_j     <= w_j_nxt;
            r_drain <= w_drain_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_rd_en <= w_issue;
            r_rd_a  <= w_rd_a_nxt;
            r_rd_b  <= w_rd_b_nxt;
            r_tw    <= w_tw_nxt;
            r_pipe_en[0] <= r_rd_en;
            r_pipe_a[0]  <= r_rd_a;
            r_pipe_b[0]  <= r_rd_b;
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_pipe_en[i] <= r_pipe_en[i-1];
                r_pipe_a[i]  <= r_pipe_a[i-1];
                r_pipe_b[i]  <= r_pipe_b[i-1];
            end
        end
    end

    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;
    assign io_bus.stage     = r_stage;
    assign io_bus.rd_en     = r_rd_en;
    assign io_bus.rd_addr_a = r_rd_a;
    assign io_bus.rd_addr_b = r_rd_b;
    assign io_bus.tw_idx    = r_tw;
    assign io_bus.wr_en     = r_pipe_en[PIPE_LAT-1];
    assign io_bus.wr_addr_a = r_pipe_a[PIPE_LAT-1];
    assign io_bus.wr_addr_b = r_pipe_b[PIPE_LAT-1];
endmodule
